apb_bridge_fsm: RTL

Parametrised AHB-to-APB3 bridge controller. Takes single AHB transfers from the AHB slave interface and drives an APB3 master port with NSLV one-hot selects. Adds per-slave pready wait states, pslverr, decode-error and timeout error responses (two-cycle AHB ERROR), and back-to-back acceptance. Sits between the AHB slave interface/decoder and the APB slave mux.

---
 rtl/apb_bridge_fsm_if.sv | 38 +++
 rtl/apb_bridge_fsm.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/apb_bridge_fsm_if.sv
// apb_bridge_fsm_if: AHB slave-side and APB master-side signals of the bridge.
// master = the bridge itself, slave = the surrounding AHB/APB environment.
interface apb_bridge_fsm_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NSLV   = 3
);
  logic                   valid;
  logic                   hwrite;
  logic [ADDR_W-1:0]      haddr;
  logic [DATA_W-1:0]      hwdata;
  logic [NSLV-1:0]        hsel_slv;
  logic                   hready_out;
  logic                   hresp;
  logic [DATA_W-1:0]      hrdata;
  logic [ADDR_W-1:0]      paddr;
  logic [DATA_W-1:0]      pwdata;
  logic                   pwrite;
  logic [NSLV-1:0]        psel;
  logic                   penable;
  logic [NSLV*DATA_W-1:0] prdata;
  logic [NSLV-1:0]        pready;
  logic [NSLV-1:0]        pslverr;

  modport master (
    input  valid, hwrite, haddr, hwdata, hsel_slv,
    input  prdata, pready, pslverr,
    output hready_out, hresp, hrdata,
    output paddr, pwdata, pwrite, psel, penable
  );

  modport slave (
    output valid, hwrite, haddr, hwdata, hsel_slv,
    output prdata, pready, pslverr,
    input  hready_out, hresp, hrdata,
    input  paddr, pwdata, pwrite, psel, penable
  );
endinterface

// File: rtl/apb_bridge_fsm.sv
// apb_bridge_fsm: single-transfer AHB to APB3 bridge controller.
// Wait states, slave/decode/timeout errors as two-cycle AHB ERROR.
module apb_bridge_fsm #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NSLV    = 3,
  parameter int TIMEOUT = 16
) (
  input logic              hclk,
  input logic              hreset,
  apb_bridge_fsm_if.master bus
);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WWAIT,
    S_SETUP,
    S_ACCESS,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_e;

  state_e state_q, state_d;
  state_e acc_tgt;

  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] hrdata_q, hrdata_d;
  logic [NSLV-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              hready_o;
  logic              hresp_o;
  logic [NSLV-1:0]   psel_o;
  logic              penable_o;

  logic              accept;
  logic              sel_ok;
  logic              rdy;
  logic              serr;
  logic [DATA_W-1:0] rdata;
  logic              to_hit;

  assign accept = bus.valid && hready_o;
  assign sel_ok = $onehot(bus.hsel_slv);
  assign to_hit = (TIMEOUT > 0) && (cnt_q == TO_LAST);

  // sel_q is one-hot whenever an APB access is in flight
  always_comb begin
    rdy   = 1'b0;
    serr  = 1'b0;
    rdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (sel_q[i]) begin
        rdy   = rdy | bus.pready[i];
        serr  = serr | bus.pslverr[i];
        rdata = rdata | bus.prdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    acc_tgt = S_SETUP;
    if (!sel_ok) begin
      acc_tgt = S_ERR1;
    end else if (bus.hwrite) begin
      acc_tgt = S_WWAIT;
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE,
      S_DONE,
      S_ERR2: state_d = accept ? acc_tgt : S_IDLE;
      S_WWAIT: state_d = S_SETUP;
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (rdy) begin
          state_d = serr ? S_ERR1 : S_DONE;
        end else if (to_hit) begin
          state_d = S_ERR1;
        end
      end
      S_ERR1: state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hready_o  = 1'b0;
    hresp_o   = 1'b0;
    psel_o    = '0;
    penable_o = 1'b0;
    unique case (state_q)
      S_IDLE,
      S_DONE: hready_o = 1'b1;
      S_SETUP: psel_o = sel_q;
      S_ACCESS: begin
        psel_o    = sel_q;
        penable_o = 1'b1;
      end
      S_ERR1: hresp_o = 1'b1;
      S_ERR2: begin
        hready_o = 1'b1;
        hresp_o  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    sel_d    = sel_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;
    cnt_d    = cnt_q;
    if (accept) begin
      paddr_d  = bus.haddr;
      pwrite_d = bus.hwrite;
      sel_d    = bus.hsel_slv;
    end
    if (state_q == S_WWAIT) begin
      pwdata_d = bus.hwdata;
    end
    if (state_q == S_SETUP) begin
      cnt_d = '0;
    end
    if (state_q == S_ACCESS) begin
      if (!rdy) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else if (!serr && !pwrite_q) begin
        hrdata_d = rdata;
      end
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      sel_q    <= '0;
      pwdata_q <= '0;
      hrdata_q <= '0;
      cnt_q    <= '0;
    end else begin
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      sel_q    <= sel_d;
      pwdata_q <= pwdata_d;
      hrdata_q <= hrdata_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.hready_out = hready_o;
  assign bus.hresp      = hresp_o;
  assign bus.hrdata     = hrdata_q;
  assign bus.paddr      = paddr_q;
  assign bus.pwdata     = pwdata_q;
  assign bus.pwrite     = pwrite_q;
  assign bus.psel       = psel_o;
  assign bus.penable    = penable_o;

endmodule
